// File: rtl/iob_ram_2p_fifo_ctrl_pkg.sv
// Shared types for the iob_ram_2p FIFO controller.
package iob_ram_2p_fifo_ctrl_pkg;

  // How the occupancy counter moves on a given edge.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // A push and a pop on the same edge cancel out; the caller has already
  // suppressed both while clearing.
  function automatic lvl_op_e lvl_op(input logic push, input logic pop);
    if (push && !pop) return LVL_INC;
    else if (pop && !push) return LVL_DEC;
    else return LVL_HOLD;
  endfunction

endpackage

// File: rtl/iob_ram_2p_fifo_ctrl.sv
// Circular-buffer FIFO controller driving an external iob_ram_2p
// (one write port, one registered read port with 1-cycle latency).
module iob_ram_2p_fifo_ctrl
  import iob_ram_2p_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int          LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [LVL_W-1:0]  level_q;
  logic              r_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              push_ok;
  logic              pop_ok;
  lvl_op_e           op;

  assign w_full  = (level_q == LVL_FULL);
  assign r_empty = (level_q == '0);
  assign level   = level_q;

  // Accept logic: clr blocks both sides; full/empty gate each side alone,
  // so at full a pop still wins and at empty a push still wins.
  always_comb begin
    push_ok = w_en & ~w_full & ~clr;
    pop_ok  = r_en & ~r_empty & ~clr;
    op      = lvl_op(push_ok, pop_ok);
  end

  // RAM port drive: enables only for accepted requests.
  always_comb begin
    ext_mem_w_en   = push_ok;
    ext_mem_w_addr = wptr;
    ext_mem_w_data = w_data;
    ext_mem_r_en   = pop_ok;
    ext_mem_r_addr = rptr;
  end

  // The RAM holds its output register, so the popped word is a pass-through.
  assign r_data  = r_valid_q ? ext_mem_r_data : '0;
  assign r_valid = r_valid_q;

  // Read/write pointers; ADDR_W bits so they wrap naturally.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      level_q <= '0;
    end else if (clr) begin
      level_q <= '0;
    end else begin
      case (op)
        LVL_INC: level_q <= level_q + 1'b1;
        LVL_DEC: level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Read-valid strobe and registered error pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      r_valid_q   <= pop_ok;
      overflow_q  <= w_en & w_full & ~clr;
      underflow_q <= r_en & r_empty & ~clr;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_iob_ram_2p_fifo_ctrl.sv
// Self-checking bench for iob_ram_2p_fifo_ctrl with a behavioural RAM and
// a queue-based FIFO reference model.
module tb_iob_ram_2p_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              clr;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  logic              ext_mem_w_en;
  logic [ADDR_W-1:0] ext_mem_w_addr;
  logic [DATA_W-1:0] ext_mem_w_data;
  logic              ext_mem_r_en;
  logic [ADDR_W-1:0] ext_mem_r_addr;
  logic [DATA_W-1:0] ext_mem_r_data;

  iob_ram_2p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .arst_n(arst_n), .clr(clr),
    .w_en(w_en), .w_data(w_data), .w_full(w_full),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
    .level(level), .overflow(overflow), .underflow(underflow),
    .ext_mem_w_en(ext_mem_w_en), .ext_mem_w_addr(ext_mem_w_addr),
    .ext_mem_w_data(ext_mem_w_data), .ext_mem_r_en(ext_mem_r_en),
    .ext_mem_r_addr(ext_mem_r_addr), .ext_mem_r_data(ext_mem_r_data)
  );

  always #5 clk = ~clk;

  // Behavioural iob_ram_2p: synchronous write, registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  initial ext_mem_r_data = '0;
  always @(posedge clk) begin
    if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
    if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
  end

  // Reference model: contents as a queue, addresses as modular counters.
  logic [7:0] q[$];
  int         m_wptr, m_rptr;
  bit         m_valid, m_ov, m_uf;
  logic [7:0] m_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_wptr = 0; m_rptr = 0;
    m_valid = 0; m_ov = 0; m_uf = 0; m_rdata = '0;
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(q.size()));
    check("w_full", 32'(w_full), 32'(q.size() == DEPTH));
    check("r_empty", 32'(r_empty), 32'(q.size() == 0));
    check("r_valid", 32'(r_valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_uf));
    if (m_valid) check("r_data", 32'(r_data), 32'(m_rdata));
  endtask

  // One clock: drive just after a falling edge, check RAM drive, clock,
  // then check registered state at the next falling edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit full, empty, pu, po;
    w_en = w; w_data = d; r_en = r; clr = c;
    #1;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    pu = w && !full && !c;
    po = r && !empty && !c;
    check("mem_w_en", 32'(ext_mem_w_en), 32'(pu));
    check("mem_r_en", 32'(ext_mem_r_en), 32'(po));
    if (pu) begin
      check("mem_w_addr", 32'(ext_mem_w_addr), 32'(m_wptr));
      check("mem_w_data", 32'(ext_mem_w_data), 32'(d));
    end
    if (po) check("mem_r_addr", 32'(ext_mem_r_addr), 32'(m_rptr));
    @(posedge clk);
    m_ov    = w && full && !c;
    m_uf    = r && empty && !c;
    m_valid = po;
    if (c) begin
      q.delete(); m_wptr = 0; m_rptr = 0;
    end else begin
      if (po) begin m_rdata = q.pop_front(); m_rptr = (m_rptr + 1) % DEPTH; end
      if (pu) begin q.push_back(d); m_wptr = (m_wptr + 1) % DEPTH; end
    end
    @(negedge clk);
    check_state();
  endtask

  typedef struct {
    bit w; logic [7:0] d; bit r; bit c;
    int lvl; bit full; bit empty; bit valid; logic [7:0] rd; bit ov; bit uf;
  } vec_t;
  vec_t tbl[7];

  initial begin
    // Hand-derived vectors starting from an empty FIFO.
    tbl[0] = '{1, 8'hA1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0}; // push
    tbl[1] = '{0, 8'h00, 1, 0, 0, 0, 1, 1, 8'hA1, 0, 0}; // pop
    tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0, 1}; // pop while empty
    tbl[3] = '{1, 8'hB2, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1}; // both at empty
    tbl[4] = '{1, 8'hC3, 1, 0, 1, 0, 0, 1, 8'hB2, 0, 0}; // both at level 1
    tbl[5] = '{1, 8'hD4, 1, 1, 0, 0, 1, 0, 8'h00, 0, 0}; // clr wins
    tbl[6] = '{0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0}; // idle

    arst_n = 1'b0; clr = 0; w_en = 0; r_en = 0; w_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(r_empty), 32'd1);
    check("rst_full", 32'(w_full), 32'd0);
    check("rst_valid", 32'(r_valid), 32'd0);
    arst_n = 1'b1;
    cycle(0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      check("tbl_level", 32'(level), 32'(tbl[i].lvl));
      check("tbl_full", 32'(w_full), 32'(tbl[i].full));
      check("tbl_empty", 32'(r_empty), 32'(tbl[i].empty));
      check("tbl_valid", 32'(r_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) check("tbl_rdata", 32'(r_data), 32'(tbl[i].rd));
      check("tbl_ov", 32'(overflow), 32'(tbl[i].ov));
      check("tbl_uf", 32'(underflow), 32'(tbl[i].uf));
    end

    // Fill with 32..47, then one push too many.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'(32 + i), 0, 0);
      check("fill_level", 32'(level), 32'(i + 1));
    end
    check("fill_full", 32'(w_full), 32'd1);
    cycle(1, 8'hEE, 0, 0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    cycle(0, 8'h00, 0, 0);
    check("ovf_one_cycle", 32'(overflow), 32'd0);

    // Full with push and pop: pop wins.
    cycle(1, 8'h77, 1, 0);
    check("full_both_ov", 32'(overflow), 32'd1);
    check("full_both_lvl", 32'(level), 32'd15);
    check("full_both_rd", 32'(r_data), 32'd32);
    cycle(1, 8'd48, 0, 0);

    // Drain all 16 consecutively (33..48), then one extra pop.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 1, 0);
      check("drain_data", 32'(r_data), 32'(33 + i));
    end
    check("drain_empty", 32'(r_empty), 32'd1);
    cycle(0, 8'h00, 1, 0);
    check("udf_pulse", 32'(underflow), 32'd1);
    check("udf_valid", 32'(r_valid), 32'd0);

    // Concurrency at level 5.
    for (int i = 0; i < 5; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(5 + i), 1, 0);
      check("conc_level", 32'(level), 32'd5);
      check("conc_data", 32'(r_data), 32'(i));
    end

    // Wrap-around from pointers at 0.
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) cycle(1, 8'(100 + i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 8'h00, 1, 0);
      check("wrap_data", 32'(r_data), 32'(100 + i));
    end

    // Synchronous clear at level 7, then a round trip.
    for (int i = 0; i < 7; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h99, 1, 1);
    check("clr_level", 32'(level), 32'd0);
    check("clr_empty", 32'(r_empty), 32'd1);
    cycle(1, 8'h3C, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("clr_rt", 32'(r_data), 32'h3C);

    // Asynchronous reset between edges at level 7.
    for (int i = 0; i < 7; i++) cycle(1, 8'(i), 0, 0);
    w_en = 0; r_en = 0;
    #2 arst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(r_empty), 32'd1);
    check("arst_full", 32'(w_full), 32'd0);
    check("arst_valid", 32'(r_valid), 32'd0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    cycle(1, 8'h5A, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("arst_rt", 32'(r_data), 32'h5A);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
